if_id_decode_stage: RTL and testbench

//   IF/ID pipeline stage feeding the immediate sign extender and register file.

---
 rtl/if_id_decode_stage_if.sv | 37 +++
 rtl/if_id_decode_stage.sv | 155 +++++++++++++++
 tb/tb_if_id_decode_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_decode_stage_if.sv
// Bundle of the IF/ID stage's fetch-side and decode-side signals.
// The slave modport is the stage. The master modport is whatever drives fetch and consumes decode.
interface if_id_decode_stage_if #(
  parameter int PC_W = 32
);
  // valid/ready: a beat transfers on a rising edge where valid & ready are both high.
  // A producer holds valid and its payload stable until that transfer happens.
  // ready never depends combinationally on valid.
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc4;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc4;
  logic [5:0]      opcode;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [5:0]      funct;
  logic [15:0]     imm16;
  logic [25:0]     target26;
  logic            imm_zext;

  modport master (
    output in_valid, in_instr, in_pc4, out_ready,
    input  in_ready, out_valid, out_pc4, opcode, rs, rt, rd, shamt, funct,
           imm16, target26, imm_zext
  );

  modport slave (
    input  in_valid, in_instr, in_pc4, out_ready,
    output in_ready, out_valid, out_pc4, opcode, rs, rt, rd, shamt, funct,
           imm16, target26, imm_zext
  );
endinterface

// File: rtl/if_id_decode_stage.sv
// IF/ID stage: two-entry skid buffer that registers a MIPS instruction and PC+4, then splits out its fields.
// Define IMM_ZEXT_FLAG_EN to register the logical-immediate flag (andi/ori/xori) with each entry.
module if_id_decode_stage #(
  parameter int PC_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  if_id_decode_stage_if.slave bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [31:0]     main_instr;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] main_pc4;
  logic [PC_W-1:0] skid_pc4;
  logic            in_fire;
  logic            out_fire;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Flush takes precedence over every load, so a same-cycle input is dropped.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: load_main_in = in_fire;
        ONE: begin
          load_main_in = in_fire & out_fire;
          load_skid    = in_fire & ~out_fire;
        end
        TWO:     load_main_skid = out_fire;
        default: ;
      endcase
    end
  end

  // in_ready and out_valid are registered with the state, so neither has a combinational input path.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_instr <= '0;
      main_pc4   <= '0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else begin
      if (load_main_in) begin
        main_instr <= bus.in_instr;
        main_pc4   <= bus.in_pc4;
      end else if (load_main_skid) begin
        main_instr <= skid_instr;
        main_pc4   <= skid_pc4;
      end
      if (load_skid) begin
        skid_instr <= bus.in_instr;
        skid_pc4   <= bus.in_pc4;
      end
    end
  end

`ifdef IMM_ZEXT_FLAG_EN
  logic main_zext;
  logic skid_zext;
  logic in_zext;

  assign in_zext = (bus.in_instr[31:26] == 6'h0C) ||
                   (bus.in_instr[31:26] == 6'h0D) ||
                   (bus.in_instr[31:26] == 6'h0E);

  always_ff @(posedge clk) begin
    if (reset) begin
      main_zext <= 1'b0;
      skid_zext <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_zext <= in_zext;
      end else if (load_main_skid) begin
        main_zext <= skid_zext;
      end
      if (load_skid) begin
        skid_zext <= in_zext;
      end
    end
  end

  assign bus.imm_zext = main_zext;
`else
  assign bus.imm_zext = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc4   = main_pc4;
  assign bus.opcode    = main_instr[31:26];
  assign bus.rs        = main_instr[25:21];
  assign bus.rt        = main_instr[20:16];
  assign bus.rd        = main_instr[15:11];
  assign bus.shamt     = main_instr[10:6];
  assign bus.funct     = main_instr[5:0];
  assign bus.imm16     = main_instr[15:0];
  assign bus.target26  = main_instr[25:0];
  assign dbg_state     = state;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Directed and randomized bench for if_id_decode_stage.
// The reference model is a bounded FIFO queue of {pc4, instr} entries with a capacity of two.
module tb_if_id_decode_stage;
  localparam int PC_W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] dbg_state;

  if_id_decode_stage_if #(.PC_W(PC_W)) bus ();

  if_id_decode_stage #(.PC_W(PC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic zext_of(input logic [31:0] instr);
`ifdef IMM_ZEXT_FLAG_EN
    int op;
    op = int'(instr >> 26);
    return (op == 12) || (op == 13) || (op == 14);
`else
    return (instr == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] i;
    logic [31:0] pc;
    check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
    check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      i  = exp_q[0][31:0];
      pc = exp_q[0][63:32];
      check("out_pc4", 64'(bus.out_pc4), 64'(pc));
      check("opcode", 64'(bus.opcode), 64'(i >> 26));
      check("rs", 64'(bus.rs), 64'((i >> 21) & 32'd31));
      check("rt", 64'(bus.rt), 64'((i >> 16) & 32'd31));
      check("rd", 64'(bus.rd), 64'((i >> 11) & 32'd31));
      check("shamt", 64'(bus.shamt), 64'((i >> 6) & 32'd31));
      check("funct", 64'(bus.funct), 64'(i & 32'd63));
      check("imm16", 64'(bus.imm16), 64'(i % 32'h1_0000));
      check("target26", 64'(bus.target26), 64'(i % 32'h400_0000));
      check("imm_zext", 64'(bus.imm_zext), 64'(zext_of(i)));
    end
  endtask

  // One rising edge: advance the model from the pre-edge inputs, then compare #1 later.
  task automatic tick(output bit accepted);
    bit          out_f;
    logic [63:0] ent;
    accepted = bus.in_valid && (exp_q.size() < 2) && !reset && !flush;
    out_f    = bus.out_ready && (exp_q.size() > 0);
    ent      = {bus.in_pc4, bus.in_instr};
    @(posedge clk);
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_f) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (accepted) exp_q.push_back(ent);
    end
    #1;
    check_outputs();
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc4, input string tag);
    bit acc;
    int budget;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc4   = pc4;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 20) begin
      tick(acc);
      budget++;
    end
    check(tag, 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit acc;
    int budget;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      tick(acc);
      budget++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int sent;
    int cycles;

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc4    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick(acc);
    tick(acc);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_fields", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}, 64'd0);
    check("rst_imm_tgt", {bus.imm16, bus.target26}, 64'd0);
    check("rst_pc4", 64'(bus.out_pc4), 64'd0);
    check("rst_zext", 64'(bus.imm_zext), 64'd0);
    reset = 1'b0;

    // addi $t0,$zero,-1 with one-cycle latency
    bus.out_ready = 1'b1;
    push_one(32'h2008_FFFF, 32'h4, "t2_accept");
    check("t2_out_valid", 64'(bus.out_valid), 64'd1);
    check("t2_opcode", 64'(bus.opcode), 64'h08);
    check("t2_rs", 64'(bus.rs), 64'd0);
    check("t2_rt", 64'(bus.rt), 64'd8);
    check("t2_imm16", 64'(bus.imm16), 64'hFFFF);
    check("t2_pc4", 64'(bus.out_pc4), 64'h4);
    drain("t2_drain");

    // An all-zero word (sll nop) is an ordinary entry
    push_one(32'h0000_0000, 32'h8, "nop_accept");
    check("nop_out_valid", 64'(bus.out_valid), 64'd1);
    drain("nop_drain");

    // Backpressure: two accepted, third waits, then all three emerge in order
    bus.out_ready = 1'b0;
    n_out = 0;
    push_one($urandom, 32'h100, "t3_push_a");
    push_one($urandom, 32'h104, "t3_push_b");
    check("t3_in_ready_full", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = $urandom;
    bus.in_pc4   = 32'h108;
    tick(acc);
    check("t3_held_c", 64'(acc), 64'd0);
    bus.out_ready = 1'b1;
    push_one(bus.in_instr, 32'h108, "t3_push_c");
    drain("t3_drain");
    check("t3_out_count", 64'(n_out), 64'd3);

    // Flush while full, with an input presented in the same cycle
    bus.out_ready = 1'b0;
    push_one($urandom, 32'h200, "t4_push_a");
    push_one($urandom, 32'h204, "t4_push_b");
    bus.in_valid = 1'b1;
    bus.in_instr = $urandom;
    bus.in_pc4   = 32'h208;
    flush        = 1'b1;
    tick(acc);
    flush = 1'b0;
    check("t4_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t4_flush_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      check("t4_no_ghost", 64'(bus.out_valid), 64'd0);
    end

    // Full throughput: 100 random instructions, one per cycle
    n_out  = 0;
    sent   = 0;
    cycles = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    while (sent < 100 && cycles < 300) begin
      bus.in_instr = $urandom;
      bus.in_pc4   = 32'h1000 + 32'(sent) * 32'd4;
      tick(acc);
      cycles++;
      if (acc) sent++;
    end
    check("t5_sent", 64'(sent), 64'd100);
    check("t5_throughput", 64'(cycles), 64'd100);
    drain("t5_drain");
    check("t5_out_count", 64'(n_out), 64'd100);

    // Random handshake mix against the queue model
    for (int k = 0; k < 200; k++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_instr  = $urandom;
      bus.in_pc4    = $urandom;
      flush         = ($urandom_range(0, 31) == 0);
      tick(acc);
    end
    flush = 1'b0;
    drain("mix_drain");

    // Logical-immediate flag
    bus.out_ready = 1'b1;
    push_one(32'h3421_FFFF, 32'h300, "t6_push_ori");
`ifdef IMM_ZEXT_FLAG_EN
    check("t6_ori_zext", 64'(bus.imm_zext), 64'd1);
`else
    check("t6_ori_zext", 64'(bus.imm_zext), 64'd0);
`endif
    push_one(32'h2021_FFFF, 32'h304, "t6_push_addi");
    check("t6_addi_zext", 64'(bus.imm_zext), 64'd0);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
